// File: rtl/uart_tx_ctrl.sv
//==============================================================================
// Module      : uart_tx_ctrl
// Description : Transmit sequencer between the APB register block and the
//               UART transmitter. Captures a word on start_tx_i and issues it
//               to uart_tx as 1-4 frames, least significant byte first. Frames
//               are paced on frame_done_i and optionally gated on CTS. One
//               tx_done_o pulse is returned per word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Configuration macro:
//   UART_CTS_FLOW_EN  defined   : WAIT_CTS advances only while cts_n == 0
//                     undefined : cts_n is ignored, WAIT_CTS lasts one cycle
//------------------------------------------------------------------------------
// Parameters:
//   WORD_W   width of tx_data_i (must equal 4*FRAME_W)
//   FRAME_W  width of frame_data_o
// Ports:
//   clk           in   1        system clock
//   rst_n         in   1        asynchronous active-low reset
//   start_tx_i    in   1        1-cycle word request
//   tx_data_i     in   WORD_W   word to send, sampled on an accepted start
//   byte_cnt_i    in   2        frames to send minus 1, sampled with tx_data_i
//   cts_n         in   1        clear-to-send, active low, synchronous to clk
//   frame_done_i  in   1        1-cycle pulse: current frame shifted out
//   frame_start_o out  1        1-cycle pulse: load frame_data_o, start frame
//   frame_data_o  out  FRAME_W  byte for the current frame
//   busy_o        out  1        high whenever not IDLE
//   tx_done_o     out  1        1-cycle pulse: whole word sent
//   start_drop_o  out  1        1-cycle pulse: start_tx_i ignored while busy
//==============================================================================
`default_nettype none

module uart_tx_ctrl #(
  parameter int WORD_W  = 32,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_tx_i,
  input  logic [WORD_W-1:0]  tx_data_i,
  input  logic [1:0]         byte_cnt_i,
  input  logic               cts_n,
  input  logic               frame_done_i,
  output logic               frame_start_o,
  output logic [FRAME_W-1:0] frame_data_o,
  output logic               busy_o,
  output logic               tx_done_o,
  output logic               start_drop_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_CTS  = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WORD_W-1:0]    r_shadow;
  logic [1:0]           r_cnt;
  logic [1:0]           r_idx;

  logic                 r_frame_start;
  logic [FRAME_W-1:0]   r_frame_data;
  logic                 r_busy;
  logic                 r_tx_done;
  logic                 r_start_drop;

  logic                 w_accept;
  logic                 w_idx_inc;
  logic                 w_cts_clear;
  logic [FRAME_W-1:0]   w_frame_sel;

  //--------------------------------------------------------------------------
  // Clear-to-send qualification
  //--------------------------------------------------------------------------
`ifdef UART_CTS_FLOW_EN
  assign w_cts_clear = ~cts_n;
`else
  // Flow control compiled out: cts_n stays on the port list but has no effect.
  logic w_unused_cts;
  assign w_unused_cts = cts_n;
  assign w_cts_clear  = 1'b1;
`endif

  // A request is only taken in IDLE; anywhere else it is reported as dropped.
  assign w_accept = (r_state == IDLE) && start_tx_i;

  //--------------------------------------------------------------------------
  // Byte selection from the shadow word (LSB byte first)
  //--------------------------------------------------------------------------
  always_comb begin
    w_frame_sel = '0;
    case (r_idx)
      2'd0:    w_frame_sel = r_shadow[0*FRAME_W +: FRAME_W];
      2'd1:    w_frame_sel = r_shadow[1*FRAME_W +: FRAME_W];
      2'd2:    w_frame_sel = r_shadow[2*FRAME_W +: FRAME_W];
      default: w_frame_sel = r_shadow[3*FRAME_W +: FRAME_W];
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idx_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_tx_i) begin
          w_state_nxt = WAIT_CTS;
        end
      end
      WAIT_CTS: begin
        if (w_cts_clear) begin
          w_state_nxt = START;
        end
      end
      START: begin
        // frame_done_i is deliberately not looked at here: a done pulse that
        // coincides with frame_start_o cannot belong to this frame.
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (frame_done_i) begin
          if (r_idx == r_cnt) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_inc   = 1'b1;
            w_state_nxt = WAIT_CTS;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Word context: shadow copy, frame count and frame index
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_cnt    <= 2'd0;
      r_idx    <= 2'd0;
    end else begin
      if (w_accept) begin
        r_shadow <= tx_data_i;
        r_cnt    <= byte_cnt_i;
        r_idx    <= 2'd0;
      end else if (w_idx_inc) begin
        // Only incremented while idx != cnt, so it never wraps.
        r_idx    <= r_idx + 2'd1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Registered outputs
  // Each output is computed from the next state so that the flop presents
  // the value during the cycle the FSM actually sits in that state.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
      r_frame_data  <= '0;
      r_busy        <= 1'b0;
      r_tx_done     <= 1'b0;
      r_start_drop  <= 1'b0;
    end else begin
      r_frame_start <= (w_state_nxt == START);
      r_busy        <= (w_state_nxt != IDLE);
      r_tx_done     <= (w_state_nxt == DONE);
      r_start_drop  <= start_tx_i && (r_state != IDLE);
      // idx already points at the upcoming frame when START is entered
      // (it advances on the WAIT_DONE -> WAIT_CTS transition).
      if (w_state_nxt == START) begin
        r_frame_data <= w_frame_sel;
      end
    end
  end

  assign frame_start_o = r_frame_start;
  assign frame_data_o  = r_frame_data;
  assign busy_o        = r_busy;
  assign tx_done_o     = r_tx_done;
  assign start_drop_o  = r_start_drop;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
//==============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Directed, self-checking bench for uart_tx_ctrl. Every output
//               is compared cycle by cycle against hand-computed values.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_ctrl;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic        start_tx_i   = 1'b0;
  logic [31:0] tx_data_i    = 32'h0;
  logic [1:0]  byte_cnt_i   = 2'd0;
  logic        cts_n        = 1'b0;
  logic        frame_done_i = 1'b0;
  logic        frame_start_o;
  logic [7:0]  frame_data_o;
  logic        busy_o;
  logic        tx_done_o;
  logic        start_drop_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .WORD_W  (32),
    .FRAME_W (8)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_tx_i    (start_tx_i),
    .tx_data_i     (tx_data_i),
    .byte_cnt_i    (byte_cnt_i),
    .cts_n         (cts_n),
    .frame_done_i  (frame_done_i),
    .frame_start_o (frame_start_o),
    .frame_data_o  (frame_data_o),
    .busy_o        (busy_o),
    .tx_done_o     (tx_done_o),
    .start_drop_o  (start_drop_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_fs"},   frame_start_o, 32'h0);
    check_val({tag, "_data"}, frame_data_o,  32'h0);
    check_val({tag, "_busy"}, busy_o,        32'h0);
    check_val({tag, "_done"}, tx_done_o,     32'h0);
    check_val({tag, "_drop"}, start_drop_o,  32'h0);
  endtask

  // Send one word with CTS clear. Must be entered in an IDLE cycle.
  //   drop_f : frame whose WAIT_DONE gets a second (ignored) start, -1 = none
  //   spur_f : frame whose WAIT_CTS and START cycles see frame_done_i, -1 = none
  //   rst_f  : frame whose WAIT_DONE gets an async reset (word abandoned), -1 = none
  task automatic send_word(input logic [31:0] data, input logic [1:0] cnt,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input int drop_f, input int spur_f, input int rst_f);
    logic [7:0] exp_b [4];
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;

    check_val("idle_busy", busy_o, 32'h0);
    start_tx_i = 1'b1; tx_data_i = data; byte_cnt_i = cnt;
    step();
    start_tx_i = 1'b0; tx_data_i = 32'h0; byte_cnt_i = 2'd0;

    for (int f = 0; f <= int'(cnt); f++) begin
      // WAIT_CTS
      check_val("wcts_fs",   frame_start_o, 32'h0);
      check_val("wcts_busy", busy_o,        32'h1);
      check_val("wcts_done", tx_done_o,     32'h0);
      frame_done_i = (f == spur_f);
      step();
      // START
      check_val("start_fs",   frame_start_o, 32'h1);
      check_val("start_data", frame_data_o,  {24'h0, exp_b[f]});
      frame_done_i = (f == spur_f);
      step();
      frame_done_i = 1'b0;
      // WAIT_DONE, first cycle
      check_val("wd_fs",   frame_start_o, 32'h0);
      check_val("wd_hold", frame_data_o,  {24'h0, exp_b[f]});
      check_val("wd_done", tx_done_o,     32'h0);
      if (f == rst_f) begin
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_all_zero("rst_idle");
        return;
      end
      if (f == drop_f) begin
        start_tx_i = 1'b1; tx_data_i = 32'h1111_1111; byte_cnt_i = 2'd0;
      end
      step();
      start_tx_i = 1'b0; tx_data_i = 32'h0; byte_cnt_i = 2'd0;
      // WAIT_DONE, second cycle
      check_val("wd_drop", start_drop_o, (f == drop_f) ? 32'h1 : 32'h0);
      check_val("wd_busy", busy_o,       32'h1);
      frame_done_i = 1'b1;
      step();
      frame_done_i = 1'b0;
    end

    // DONE
    check_val("done_pulse", tx_done_o,     32'h1);
    check_val("done_busy",  busy_o,        32'h1);
    check_val("done_fs",    frame_start_o, 32'h0);
    step();
    // IDLE again
    check_val("idle_done", tx_done_o, 32'h0);
    check_val("idle_busy", busy_o,    32'h0);
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset");

    // T1: single byte
    send_word(32'hA5A5_1234, 2'd0, 8'h34, 8'h00, 8'h00, 8'h00, -1, -1, -1);

    // T2: four bytes, LSB first
    send_word(32'hDEAD_BEEF, 2'd3, 8'hEF, 8'hBE, 8'hAD, 8'hDE, -1, -1, -1);

    // T3: CTS gating
    cts_n = 1'b1;
    start_tx_i = 1'b1; tx_data_i = 32'h0000_00C3; byte_cnt_i = 2'd0;
    step();
    start_tx_i = 1'b0; tx_data_i = 32'h0; byte_cnt_i = 2'd0;
`ifdef UART_CTS_FLOW_EN
    for (int i = 0; i < 20; i++) begin
      check_val("cts_hold_fs",   frame_start_o, 32'h0);
      check_val("cts_hold_busy", busy_o,        32'h1);
      step();
    end
    cts_n = 1'b0;
    check_val("cts_rel_fs", frame_start_o, 32'h0);
    step();
`else
    check_val("cts_ign_fs", frame_start_o, 32'h0);
    step();
`endif
    check_val("cts_start_fs",   frame_start_o, 32'h1);
    check_val("cts_start_data", frame_data_o,  32'hC3);
    step();
    frame_done_i = 1'b1;
    step();
    frame_done_i = 1'b0;
    check_val("cts_done", tx_done_o, 32'h1);
    step();
    check_val("cts_idle", busy_o, 32'h0);
    cts_n = 1'b0;

    // T4: start while busy is dropped; back-to-back start after DONE accepted
    send_word(32'h8765_4321, 2'd2, 8'h21, 8'h43, 8'h65, 8'h00, 0, -1, -1);
    send_word(32'hCAFE_F00D, 2'd1, 8'h0D, 8'hF0, 8'h00, 8'h00, -1, -1, -1);

    // T5: spurious frame_done_i in IDLE, WAIT_CTS and START
    frame_done_i = 1'b1;
    step();
    frame_done_i = 1'b0;
    check_val("spur_idle_busy", busy_o,        32'h0);
    check_val("spur_idle_done", tx_done_o,     32'h0);
    check_val("spur_idle_fs",   frame_start_o, 32'h0);
    step();
    check_val("spur_idle_done2", tx_done_o, 32'h0);
    send_word(32'h0000_5AC3, 2'd1, 8'hC3, 8'h5A, 8'h00, 8'h00, -1, 1, -1);

    // T6: reset in WAIT_DONE of frame 2 of 4, then a fresh word from byte 0
    send_word(32'hDEAD_BEEF, 2'd3, 8'hEF, 8'hBE, 8'hAD, 8'hDE, -1, -1, 1);
    send_word(32'h4433_2211, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
